// File: rtl/z80_rot_dec_seq.sv
`default_nettype none
// ============================================================================
// Module      : z80_rot_dec_seq
// Description : Sequencer for the Z80 RLD / RRD nibble-rotate instructions.
//               It accepts one request and reads the operand byte at HL.
//               It then rotates the low nibble of A through the operand byte,
//               writes the byte back, and reports the new A and flags with a
//               one-cycle done pulse.
//
//               Optional build macro Z80_ROTDEC_TSTATE_EN:
//                 defined   -> EXEC lasts EXEC_CYCLES cycles, timed by a
//                              4-bit down-counter. This mimics the Z80's
//                              internal T-states.
//                 undefined -> EXEC lasts a single cycle.
//
// Parameters  : EXEC_CYCLES  EXEC length when the macro is defined (1..15)
//
// Ports       : clk         clock, rising edge active
//               reset_n     synchronous active-low reset
//               start       begin one RLD/RRD (sampled in IDLE only)
//               left        1 = RLD, 0 = RRD (captured with start)
//               hl_in       operand address (captured with start)
//               a_in        accumulator (captured with start)
//               f_in        flags (captured with start)
//               busy        high whenever the sequencer is not idle
//               mem_addr    captured HL, held for the whole operation
//               mem_rd_req  read request, held until mem_ack
//               mem_rdata   read data, valid with mem_ack during the read
//               mem_wr_req  write request, held until mem_ack
//               mem_wdata   write-back byte, stable during mem_wr_req
//               mem_ack     memory completion strobe
//               done        one-cycle completion pulse
//               a_out       resulting accumulator
//               f_out       resulting flags {S,Z,f5,H,f3,P,N,C}
//
// Revision    : 1.0  initial release
// ============================================================================
module z80_rot_dec_seq #(
    parameter int EXEC_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        left,
    input  logic [15:0] hl_in,
    input  logic [7:0]  a_in,
    input  logic [7:0]  f_in,
    output logic        busy,
    output logic [15:0] mem_addr,
    output logic        mem_rd_req,
    input  logic [7:0]  mem_rdata,
    output logic        mem_wr_req,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    output logic        done,
    output logic [7:0]  a_out,
    output logic [7:0]  f_out
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_EXEC = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Operands captured at start / read completion
    logic        r_left;
    logic [7:0]  r_a;
    logic [7:0]  r_f;
    logic [7:0]  r_m;

    logic        w_left_nxt;
    logic [7:0]  w_a_nxt;
    logic [7:0]  w_f_nxt;
    logic [7:0]  w_m_nxt;

    // Next values of the registered outputs
    logic        w_busy_nxt;
    logic        w_rd_req_nxt;
    logic        w_wr_req_nxt;
    logic        w_done_nxt;
    logic [15:0] w_addr_nxt;
    logic [7:0]  w_wdata_nxt;
    logic [7:0]  w_a_out_nxt;
    logic [7:0]  w_f_out_nxt;

    // Rotation result
    logic [7:0]  w_res_a;
    logic [7:0]  w_res_wdata;
    logic [7:0]  w_res_f;

`ifdef Z80_ROTDEC_TSTATE_EN
    // The counter holds the number of EXEC cycles still to go after the current one.
    localparam logic [3:0] c_exec_load = 4'(EXEC_CYCLES - 1);

    logic [3:0]  r_exec_cnt;
    logic [3:0]  w_exec_cnt_nxt;
`else
    // EXEC is a single cycle in this build, so EXEC_CYCLES has no effect.
    logic        w_unused_exec_cycles;
    assign w_unused_exec_cycles = (EXEC_CYCLES != 0);
`endif

    // ------------------------------------------------------------------------
    // Nibble rotation. The 16-bit value {A, M} is rearranged as follows:
    //   RLD: {A_hi, M_hi, M_lo, A_lo}
    //   RRD: {A_hi, M_lo, A_lo, M_hi}
    // The upper byte becomes the new A and the lower byte is written back.
    // ------------------------------------------------------------------------
    always_comb begin
        if (r_left) begin
            w_res_a     = {r_a[7:4], r_m[7:4]};
            w_res_wdata = {r_m[3:0], r_a[3:0]};
        end else begin
            w_res_a     = {r_a[7:4], r_m[3:0]};
            w_res_wdata = {r_a[3:0], r_m[7:4]};
        end
    end

    // H and N are cleared. f5, f3 and C pass through from the captured F.
    // P is set for even parity, so it is the inverse of the XOR reduction.
    assign w_res_f = {w_res_a[7], (w_res_a == 8'h00), r_f[5], 1'b0,
                      r_f[3], ~^w_res_a, 1'b0, r_f[0]};

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_left_nxt     = r_left;
        w_a_nxt        = r_a;
        w_f_nxt        = r_f;
        w_m_nxt        = r_m;
        w_addr_nxt     = mem_addr;
        w_wdata_nxt    = mem_wdata;
        w_a_out_nxt    = a_out;
        w_f_out_nxt    = f_out;
`ifdef Z80_ROTDEC_TSTATE_EN
        w_exec_cnt_nxt = r_exec_cnt;
`endif

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_left_nxt  = left;
                    w_addr_nxt  = hl_in;
                    w_a_nxt     = a_in;
                    w_f_nxt     = f_in;
                    w_state_nxt = ST_RD;
                end
            end

            ST_RD: begin
                if (mem_ack) begin
                    w_m_nxt        = mem_rdata;
                    w_state_nxt    = ST_EXEC;
`ifdef Z80_ROTDEC_TSTATE_EN
                    w_exec_cnt_nxt = c_exec_load;
`endif
                end
            end

            ST_EXEC: begin
`ifdef Z80_ROTDEC_TSTATE_EN
                if (r_exec_cnt == 4'd0) begin
                    w_wdata_nxt = w_res_wdata;
                    w_state_nxt = ST_WR;
                end else begin
                    w_exec_cnt_nxt = r_exec_cnt - 4'd1;
                end
`else
                w_wdata_nxt = w_res_wdata;
                w_state_nxt = ST_WR;
`endif
            end

            ST_WR: begin
                if (mem_ack) begin
                    // Operands are still held, so the result is recomputed here.
                    // This avoids keeping a separate copy of the result.
                    w_a_out_nxt = w_res_a;
                    w_f_out_nxt = w_res_f;
                    w_state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // All status outputs are registered, and each is decoded from the state being entered.
    assign w_busy_nxt   = (w_state_nxt != ST_IDLE);
    assign w_rd_req_nxt = (w_state_nxt == ST_RD);
    assign w_wr_req_nxt = (w_state_nxt == ST_WR);
    assign w_done_nxt   = (w_state_nxt == ST_DONE);

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_left     <= 1'b0;
            r_a        <= 8'h00;
            r_f        <= 8'h00;
            r_m        <= 8'h00;
            busy       <= 1'b0;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            done       <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 8'h00;
            a_out      <= 8'h00;
            f_out      <= 8'h00;
`ifdef Z80_ROTDEC_TSTATE_EN
            r_exec_cnt <= 4'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_left     <= w_left_nxt;
            r_a        <= w_a_nxt;
            r_f        <= w_f_nxt;
            r_m        <= w_m_nxt;
            busy       <= w_busy_nxt;
            mem_rd_req <= w_rd_req_nxt;
            mem_wr_req <= w_wr_req_nxt;
            done       <= w_done_nxt;
            mem_addr   <= w_addr_nxt;
            mem_wdata  <= w_wdata_nxt;
            a_out      <= w_a_out_nxt;
            f_out      <= w_f_out_nxt;
`ifdef Z80_ROTDEC_TSTATE_EN
            r_exec_cnt <= w_exec_cnt_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_z80_rot_dec_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_z80_rot_dec_seq
// Description : Self-checking bench for z80_rot_dec_seq. It drives directed
//               and random RLD/RRD operations, and a memory responder with
//               programmable wait states answers them. Every result is
//               compared with a nibble-level model of the instructions.
// Revision    : 1.0  initial release
// ============================================================================
module tb_z80_rot_dec_seq;

    localparam int TB_EXEC_CYCLES = 4;
`ifdef Z80_ROTDEC_TSTATE_EN
    localparam int EXP_EXEC = TB_EXEC_CYCLES;
`else
    localparam int EXP_EXEC = 1;
`endif

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        start     = 1'b0;
    logic        left      = 1'b0;
    logic [15:0] hl_in     = 16'h0000;
    logic [7:0]  a_in      = 8'h00;
    logic [7:0]  f_in      = 8'h00;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack   = 1'b0;

    logic        busy;
    logic [15:0] mem_addr;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [7:0]  mem_wdata;
    logic        done;
    logic [7:0]  a_out;
    logic [7:0]  f_out;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [7:0]  last_a;
    logic [7:0]  last_f;
    logic [7:0]  last_wd;

    always #5 clk = ~clk;

    z80_rot_dec_seq #(
        .EXEC_CYCLES (TB_EXEC_CYCLES)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .left       (left),
        .hl_in      (hl_in),
        .a_in       (a_in),
        .f_in       (f_in),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_rd_req (mem_rd_req),
        .mem_rdata  (mem_rdata),
        .mem_wr_req (mem_wr_req),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .done       (done),
        .a_out      (a_out),
        .f_out      (f_out)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Z80 semantics stated nibble by nibble.
    //   RLD: A_lo <- M_hi, M_hi <- M_lo, M_lo <- A_lo
    //   RRD: A_lo <- M_lo, M_lo <- M_hi, M_hi <- A_lo
    function automatic void model(input bit lft, input logic [7:0] a, input logic [7:0] f,
                                  input logic [7:0] m, output logic [7:0] ea,
                                  output logic [7:0] ewd, output logic [7:0] ef);
        ea = a;
        if (lft) begin
            ea[3:0] = m[7:4];
            ewd     = {m[3:0], a[3:0]};
        end else begin
            ea[3:0] = m[3:0];
            ewd     = {a[3:0], m[7:4]};
        end
        ef    = 8'h00;
        ef[7] = ea[7];
        ef[6] = (ea == 8'h00);
        ef[5] = f[5];
        ef[3] = f[3];
        ef[2] = (($countones(ea) % 2) == 0);
        ef[0] = f[0];
    endfunction

    task automatic run_op(input string tag, input bit lft, input logic [15:0] hl,
                          input logic [7:0] a, input logic [7:0] f, input logic [7:0] m,
                          input int rdw, input int wrw, input bit poke);
        logic [7:0] ea, ewd, ef, wd_first;
        int         cyc, rd_cnt, wr_cnt, done_cyc, exp_cyc;
        bit         overlap, busy_drop, addr_bad, wd_unstable;
        model(lft, a, f, m, ea, ewd, ef);
        exp_cyc = 1 + (rdw + 1) + EXP_EXEC + (wrw + 1);

        start = 1'b1; left = lft; hl_in = hl; a_in = a; f_in = f;
        tick();
        start = 1'b0; left = ~lft;
        hl_in = 16'($urandom); a_in = 8'($urandom); f_in = 8'($urandom);

        cyc = 1; rd_cnt = 0; wr_cnt = 0; done_cyc = -1; wd_first = 8'h00;
        overlap = 0; busy_drop = 0; addr_bad = 0; wd_unstable = 0;
        while (done_cyc < 0 && cyc < 300) begin
            if (mem_rd_req && mem_wr_req) overlap = 1;
            if (!busy) busy_drop = 1;
            if (mem_addr !== hl) addr_bad = 1;
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            if (mem_rd_req) begin
                rd_cnt++;
                if (rd_cnt == rdw + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = m;
                end
            end
            if (mem_wr_req) begin
                wr_cnt++;
                if (wr_cnt == 1) wd_first = mem_wdata;
                else if (mem_wdata !== wd_first) wd_unstable = 1;
                if (wr_cnt == wrw + 1) mem_ack = 1'b1;
            end
            // Stray acks outside a request must be ignored.
            if (!mem_rd_req && !mem_wr_req) mem_ack = 1'($urandom_range(0, 1));
            if (done) begin
                done_cyc = cyc;
                last_a   = a_out;
                last_f   = f_out;
            end
            start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            cyc++;
        end
        start   = 1'b0;
        mem_ack = 1'b0;
        last_wd = wd_first;

        check_val({tag, " done_latency"}, done_cyc, exp_cyc);
        check_val({tag, " rd_req_cycles"}, rd_cnt, rdw + 1);
        check_val({tag, " wr_req_cycles"}, wr_cnt, wrw + 1);
        check_val({tag, " mem_wdata"}, wd_first, ewd);
        check_val({tag, " a_out"}, last_a, ea);
        check_val({tag, " f_out"}, last_f, ef);
        check_val({tag, " req_overlap"}, overlap, 0);
        check_val({tag, " busy_gap"}, busy_drop, 0);
        check_val({tag, " mem_addr"}, addr_bad, 0);
        check_val({tag, " wdata_stable"}, wd_unstable, 0);
        check_val({tag, " done_pulse_end"}, done, 0);
        check_val({tag, " idle_busy"}, busy, 0);
        check_val({tag, " a_out_held"}, a_out, ea);
    endtask

    // Start an operation and wait for the read or write phase. Then apply reset
    // together with ack and start, and confirm that the operation is abandoned.
    task automatic reset_in(input string tag, input bit in_wr);
        int guard;
        bit bad;
        start = 1'b1; left = 1'b1; hl_in = 16'h1234; a_in = 8'h5A; f_in = 8'hFF;
        tick();
        start = 1'b0;
        guard = 0;
        while (!(in_wr ? mem_wr_req : mem_rd_req) && guard < 50) begin
            mem_ack   = in_wr ? mem_rd_req : 1'b0;
            mem_rdata = 8'h3C;
            tick();
            guard++;
        end
        check_val({tag, " phase_reached"}, in_wr ? mem_wr_req : mem_rd_req, 1);
        reset_n = 1'b0; mem_ack = 1'b1; start = 1'b1;
        tick();
        check_val({tag, " rd_req"}, mem_rd_req, 0);
        check_val({tag, " wr_req"}, mem_wr_req, 0);
        check_val({tag, " busy"}, busy, 0);
        check_val({tag, " done"}, done, 0);
        check_val({tag, " mem_addr"}, mem_addr, 0);
        check_val({tag, " mem_wdata"}, mem_wdata, 0);
        check_val({tag, " a_out"}, a_out, 0);
        reset_n = 1'b1; start = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            tick();
            if (done || mem_rd_req || mem_wr_req || busy) bad = 1;
        end
        mem_ack = 1'b0;
        check_val({tag, " abandoned"}, bad, 0);
    endtask

    initial begin
        bit idle_bad;

        // Reset with start and ack asserted: reset must win.
        reset_n = 1'b0; start = 1'b1; mem_ack = 1'b1;
        repeat (3) tick();
        check_val("rst busy", busy, 0);
        check_val("rst mem_rd_req", mem_rd_req, 0);
        check_val("rst mem_wr_req", mem_wr_req, 0);
        check_val("rst done", done, 0);
        check_val("rst mem_addr", mem_addr, 0);
        check_val("rst mem_wdata", mem_wdata, 0);
        check_val("rst a_out", a_out, 0);
        check_val("rst f_out", f_out, 0);
        reset_n = 1'b1; start = 1'b0; mem_ack = 1'b0;

        // No start -> stays idle
        idle_bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy || mem_rd_req || mem_wr_req || done) idle_bad = 1;
        end
        check_val("idle_hold", idle_bad, 0);

        // Directed vectors
        run_op("rld_84", 1'b1, 16'hC000, 8'h84, 8'h29, 8'h20, 0, 0, 1'b0);
        check_val("rld_84 const a_out", last_a, 8'h82);
        check_val("rld_84 const f_out", last_f, 8'hAD);
        check_val("rld_84 const wdata", last_wd, 8'h04);

        run_op("rrd_84", 1'b0, 16'hC001, 8'h84, 8'h29, 8'h20, 0, 0, 1'b0);
        check_val("rrd_84 const a_out", last_a, 8'h80);
        check_val("rrd_84 const f_out", last_f, 8'hA9);
        check_val("rrd_84 const wdata", last_wd, 8'h42);

        run_op("rrd_zero", 1'b0, 16'h0000, 8'h0F, 8'h00, 8'h00, 0, 0, 1'b0);
        check_val("rrd_zero const a_out", last_a, 8'h00);
        check_val("rrd_zero const f_out", last_f, 8'h44);
        check_val("rrd_zero const wdata", last_wd, 8'hF0);

        // Wait states with start pulses while busy
        run_op("wait_3_2", 1'b1, 16'hBEEF, 8'h3C, 8'hD7, 8'hA5, 3, 2, 1'b1);

        // Reset abandons an operation
        reset_in("rst_in_wr", 1'b1);
        reset_in("rst_in_rd", 1'b0);

        // Randomized back-to-back operations
        for (int i = 0; i < 40; i++) begin
            run_op("rand", 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                   8'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
